// File: rtl/mmio_pkg.sv
// mmio_pkg: register map and shared constants for memory-mapped peripherals.
// Rev 1.0
`default_nettype none

package mmio_pkg;

  localparam int WIN_BYTES  = 32;
  localparam int WIN_BITS   = $clog2(WIN_BYTES);
  localparam int PRESCALE_W = 16;

  localparam logic [WIN_BITS-1:0] OFS_CTRL     = 5'h00;
  localparam logic [WIN_BITS-1:0] OFS_LOAD     = 5'h04;
  localparam logic [WIN_BITS-1:0] OFS_COUNT    = 5'h08;
  localparam logic [WIN_BITS-1:0] OFS_STATUS   = 5'h0C;
  localparam logic [WIN_BITS-1:0] OFS_PRESCALE = 5'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;

  // Field order matches the CTRL bit indices so the struct maps directly onto rdata[2:0].
  typedef struct packed {
    logic ie;
    logic reload;
    logic en;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// tick_gen: prescale counter producing one tick every prescale+1 enabled cycles.
// Rev 1.0
`default_nettype none

module tick_gen
  import mmio_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick,
  output logic [PRESCALE_W-1:0] pc
);

  assign tick = en && (pc == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (!en || clr || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, auto-reload and irq.
// Rev 1.0
`default_nettype none

module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'hFFFF_0000,
  parameter int          WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t                 ctrl;
  logic                  expired;
  logic [WIDTH-1:0]      load;
  logic [WIDTH-1:0]      count;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pc;
  logic                  tick;
  logic                  clr;
  logic                  zero_tick;
  logic [WIN_BITS-1:0]   ofs;
  logic                  wr;
  logic                  wr_ctrl;
  logic                  wr_load;
  logic                  wr_status;
  logic                  wr_prescale;

  assign hit = (addr[31:WIN_BITS] == BASE[31:WIN_BITS]);
  // Word access only: byte lanes are masked off the offset.
  assign ofs = addr[WIN_BITS-1:0] & 5'b11100;

  assign wr          = memwrite && hit;
  assign wr_ctrl     = wr && (ofs == OFS_CTRL);
  assign wr_load     = wr && (ofs == OFS_LOAD);
  assign wr_status   = wr && (ofs == OFS_STATUS);
  assign wr_prescale = wr && (ofs == OFS_PRESCALE);

  assign zero_tick = tick && (count == '0);

  // Restart the prescaler when en toggles, or when a new PRESCALE would strand pc above it.
  assign clr = (wr_ctrl && (writedata[CTRL_EN] != ctrl.en)) ||
               (wr_prescale && (writedata[PRESCALE_W-1:0] < pc));

  tick_gen u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl.en),
    .clr      (clr),
    .prescale (prescale),
    .tick     (tick),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      load     <= '0;
      count    <= '0;
      expired  <= 1'b0;
      prescale <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl.en     <= writedata[CTRL_EN];
        ctrl.reload <= writedata[CTRL_RELOAD];
        ctrl.ie     <= writedata[CTRL_IE];
      end else if (zero_tick && !ctrl.reload) begin
        ctrl.en <= 1'b0;
      end

      if (wr_load) begin
        load  <= writedata[WIDTH-1:0];
        count <= writedata[WIDTH-1:0];
      end else if (tick) begin
        if (count != '0) begin
          count <= count - WIDTH'(1);
        end else if (ctrl.reload) begin
          count <= load;
        end
      end

      // Expiry outranks a same-edge write-1-to-clear.
      if (zero_tick) begin
        expired <= 1'b1;
      end else if (wr_status && writedata[0]) begin
        expired <= 1'b0;
      end

      if (wr_prescale) begin
        prescale <= writedata[PRESCALE_W-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (ofs)
        OFS_CTRL:     rdata = {29'd0, ctrl};
        OFS_LOAD:     rdata = 32'(load);
        OFS_COUNT:    rdata = 32'(count);
        OFS_STATUS:   rdata = {31'd0, expired};
        OFS_PRESCALE: rdata = 32'(prescale);
        default:      rdata = '0;
      endcase
    end
  end

  assign irq = expired & ctrl.ie;

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed stimulus with a behavioural register-map model checked every cycle.
// Rev 1.0
`default_nettype none

module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_LOAD = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_PS   = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_timer #(.BASE(BASE), .WIDTH(32)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .hit       (hit),
    .rdata     (rdata),
    .irq       (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  // Behavioural model: register values as the programmer sees them.
  bit          m_en = 0, m_rl = 0, m_ie = 0, m_exp = 0;
  int unsigned m_load = 0, m_count = 0, m_ps = 0, m_pc = 0;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd31);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    if (!in_win(a)) return 32'h0;
    off = a - BASE;
    case (off[4:2])
      3'd0:    return {29'd0, m_ie, m_rl, m_en};
      3'd1:    return m_load;
      3'd2:    return m_count;
      3'd3:    return {31'd0, m_exp};
      3'd4:    return m_ps;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin : m_step
    bit          w, tk, fire, nen;
    int unsigned ri;
    if (!reset) begin
      m_en <= 0; m_rl <= 0; m_ie <= 0; m_exp <= 0;
      m_load <= 0; m_count <= 0; m_ps <= 0; m_pc <= 0;
    end else begin
      w    = memwrite && in_win(addr);
      ri   = (addr - BASE) / 4;
      tk   = m_en && (m_pc == m_ps);
      fire = tk && (m_count == 0);
      if (w && ri == 0)       nen = writedata[0];
      else if (fire && !m_rl) nen = 1'b0;
      else                    nen = m_en;
      m_en <= nen;
      if (w && ri == 0) begin
        m_rl <= writedata[1];
        m_ie <= writedata[2];
      end
      if (w && ri == 1) begin
        m_load  <= writedata;
        m_count <= writedata;
      end else if (tk) begin
        if (m_count != 0) m_count <= m_count - 1;
        else if (m_rl)    m_count <= m_load;
      end
      if (fire)                                  m_exp <= 1'b1;
      else if (w && ri == 3 && writedata[0])     m_exp <= 1'b0;
      if (w && ri == 4) m_ps <= 32'(writedata[15:0]);
      // pc sits at 0 whenever disabled and restarts on enable.
      if (!nen || !m_en)                                       m_pc <= 0;
      else if (w && ri == 4 && 32'(writedata[15:0]) < m_pc)    m_pc <= 0;
      else if (tk)                                             m_pc <= 0;
      else                                                     m_pc <= m_pc + 1;
    end
  end

  always @(negedge clk) begin : cmp
    check("hit", 32'(hit), 32'(in_win(addr)));
    check("rdata", rdata, m_read(addr));
    check("irq", 32'(irq), 32'(m_exp && m_ie));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0; addr = 32'h0; writedata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] want, input string nm);
    addr = a; memwrite = 1'b0;
    #1;
    check(nm, rdata, want);
  endtask

  initial begin
    cyc(2);
    reset = 1'b1;
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_LOAD, 32'h0, "rst_load");
    rd(A_CNT,  32'h0, "rst_count");
    rd(A_STAT, 32'h0, "rst_status");
    rd(A_PS,   32'h0, "rst_prescale");
    check("rst_irq", 32'(irq), 32'h0);

    // One-shot: expiry exactly 4 edges after the CTRL write.
    wr(A_PS, 32'd0);
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);
    cyc(3);
    rd(A_STAT, 32'h0, "os_status_early");
    check("os_irq_early", 32'(irq), 32'h0);
    cyc(1);
    rd(A_STAT, 32'h1, "os_status");
    check("os_irq", 32'(irq), 32'h1);
    rd(A_CTRL, 32'h4, "os_ctrl_stop");
    cyc(2);
    rd(A_CNT, 32'h0, "os_count_hold");
    wr(A_STAT, 32'h1);
    wr(A_CTRL, 32'h0);
    check("os_irq_clear", 32'(irq), 32'h0);

    // Auto-reload with PRESCALE=2: ticks every 3 edges.
    wr(A_PS, 32'd2);
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h3);
    cyc(2);
    rd(A_CNT, 32'd1, "ar_count_e2");
    cyc(1);
    rd(A_CNT, 32'd0, "ar_count_e3");
    cyc(2);
    rd(A_STAT, 32'h0, "ar_status_e5");
    cyc(1);
    rd(A_STAT, 32'h1, "ar_status_e6");
    rd(A_CNT, 32'd1, "ar_count_e6");
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h0, "ar_w1c");
    cyc(4);
    rd(A_STAT, 32'h0, "ar_status_e11");
    rd(A_CNT, 32'd0, "ar_count_e11");
    cyc(1);
    rd(A_STAT, 32'h1, "ar_status_e12");
    // Clear lands on the E18 expiry edge: set must win.
    cyc(5);
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h1, "w1c_collide");
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);

    // LOAD write coinciding with a tick.
    wr(A_LOAD, 32'd7);
    wr(A_CTRL, 32'h1);
    cyc(2);
    wr(A_LOAD, 32'h10);
    rd(A_CNT, 32'h10, "ld_tick_count");
    cyc(2);
    rd(A_CNT, 32'h10, "ld_count_e5");
    cyc(1);
    rd(A_CNT, 32'h0F, "ld_count_e6");
    wr(A_CTRL, 32'h0);

    // Address decode edges.
    addr = BASE + 32'h20;
    #1;
    check("dec_hit_hi", 32'(hit), 32'h0);
    check("dec_rdata_hi", rdata, 32'h0);
    addr = BASE - 32'h4;
    #1;
    check("dec_hit_lo", 32'(hit), 32'h0);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(BASE - 32'h4, 32'hFFFF_FFFF);
    wr(A_CNT, 32'h5);
    wr(BASE + 32'h18, 32'h7);
    rd(A_LOAD, 32'h10, "dec_load");
    rd(A_CNT, 32'h0F, "dec_count");
    rd(A_CTRL, 32'h0, "dec_ctrl");
    cyc(1);
    rd(A_PS, 32'h2, "dec_prescale");
    rd(BASE + 32'h18, 32'h0, "dec_reserved");
    check("dec_hit_reserved", 32'(hit), 32'h1);

    // Reset in the middle of a count with an interrupt pending.
    wr(A_PS, 32'd0);
    wr(A_LOAD, 32'd0);
    wr(A_CTRL, 32'h5);
    cyc(1);
    check("pre_rst_irq", 32'(irq), 32'h1);
    wr(A_PS, 32'd100);
    wr(A_LOAD, 32'd5);
    wr(A_CTRL, 32'h5);
    rd(A_CNT, 32'd5, "pre_rst_count");
    reset = 1'b0;
    rd(A_CNT, 32'h0, "rst_mid_count");
    rd(A_STAT, 32'h0, "rst_mid_status");
    check("rst_mid_irq", 32'(irq), 32'h0);
    cyc(1);
    reset = 1'b1;

    // Mixed traffic left to the per-cycle model check.
    wr(A_PS, 32'd1);
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h7);
    cyc(7);
    wr(A_PS, 32'd0);
    cyc(5);
    wr(A_CTRL, 32'h7);
    cyc(3);
    wr(A_PS, 32'd3);
    cyc(10);
    wr(A_STAT, 32'h1);
    cyc(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped down-counting timer on the core's data-memory port. Consumes the core's `memwrite`, `aluout` (address) and `writedata`, and returns combinational read data plus a `hit` flag so the top-level can mux it into `readdata` ahead of data RAM. Provides a programmable prescaler, one-shot or auto-reload operation, a sticky expiry flag and a level interrupt line.

## Interface
- `BASE`, 32'hFFFF_0000: byte address of register 0; window is 32 bytes, aligned.
- `WIDTH`, 32: counter and load register width (≤ 32).
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  core store strobe.
- `addr`  in  32  byte address (core `aluout`).
- `writedata`  in  32  store data.
- `hit`  out  1  `addr` in `[BASE, BASE+0x1F]`; combinational.
- `rdata`  out  32  read data for `addr`; combinational, 0 when `hit`=0.
- `irq`  out  1  `STATUS.expired & CTRL.ie`; registered-derived, no combinational path from inputs.

## Operation
- Registers (offset from `BASE`; `addr[1:0]` ignored, word access only):
  - 0x00 CTRL: bit0 `en`, bit1 `reload` (auto-reload), bit2 `ie`; other bits read 0.
  - 0x04 LOAD: reload value; a write also copies the value into COUNT.
  - 0x08 COUNT: current value; read-only, writes ignored.
  - 0x0C STATUS: bit0 `expired`; write 1 clears, write 0 no effect.
  - 0x10 PRESCALE: 16 bits; tick every PRESCALE+1 cycles.
  - 0x14–0x1C: read 0, writes ignored.
- Write takes effect at the rising edge where `memwrite & hit`.
- Tick: internal prescale counter `pc` counts 0..PRESCALE while `en`=1; tick asserted on the cycle `pc`==PRESCALE, then `pc` returns to 0. `pc` held at 0 while `en`=0.
- On tick: if COUNT≠0, COUNT←COUNT−1. If COUNT==0: set `expired`; if `reload`, COUNT←LOAD; else `en`←0 (one-shot stop), COUNT stays 0.
- Expiry therefore occurs LOAD+1 ticks after enable.
- Narrow `WIDTH`: upper write bits dropped, reads zero-extended.

## Timing
- Reset (async assert, sync-released by upstream): CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESCALE=0, `pc`=0; outputs `irq`=0, `hit`/`rdata` follow `addr` combinationally.
- Read latency 0 cycles (single-cycle core): `rdata` reflects register state before the current edge.
- Simultaneous events, required priority:
  - STATUS clear write and expiry same edge → `expired`=1 (set wins).
  - LOAD write and tick same edge → COUNT←written value; tick's decrement/reload discarded; `expired` still set if old COUNT was 0.
  - CTRL write with `en` 0→1 → `pc` cleared to 0 at that edge; write with `en`=1 while already 1 does not disturb `pc`.
  - CTRL write and one-shot auto-clear of `en` same edge → CTRL write wins.
  - PRESCALE write lowering below current `pc` → `pc` cleared to 0 at that edge.
- Reset mid-count: all state returns to reset values immediately; no pending expiry survives.

## Structure
- Package `mmio_pkg`: register offsets (`OFS_CTRL` … `OFS_PRESCALE`), CTRL bit indices, window size constant; shared with future MMIO peripherals and the top-level read mux.
- Sub-module `tick_gen`: prescale counter with `en`, `clr`, `prescale` in, `tick` out.
- Top-level integration (outside this block): `readdata = hit ? rdata : ram_rdata`; data RAM write enable gated with `~hit`.

## Test plan
- Reset: assert `reset`=0 mid-operation with COUNT=5 → all reads return 0, `irq`=0 within same cycle.
- One-shot: PRESCALE=0, LOAD=3, CTRL=0x5 → `expired`=1 and `irq`=1 exactly 4 cycles after CTRL write; CTRL reads 0x4; COUNT stays 0.
- Auto-reload with prescale: PRESCALE=2, LOAD=1, CTRL=0x3 → `expired` sets at cycle 6; after W1C to STATUS, sets again 6 cycles later; COUNT sequence 1,0,1,0 every 3 cycles.
- Clear/set collision: W1C STATUS on the exact expiry edge → STATUS reads 1.
- LOAD/tick collision: write LOAD=0x10 on a tick edge with COUNT=7 → COUNT reads 0x10 next cycle, then 0xF after next tick.
- Decode: address BASE+0x20 and BASE−4 → `hit`=0, `rdata`=0, stores leave all registers unchanged; BASE+0x18 read → 0.
